// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared constants, tid type and helpers for the barrel thread scheduler
package barrel_pkg;

  localparam int DEFAULT_NUM_THREADS = 8;
  localparam int DEFAULT_PC_STEP     = 4;

  // Width of a thread id; a single-thread build still needs one bit.
  function automatic int tid_width(input int num_threads);
    return (num_threads > 1) ? $clog2(num_threads) : 1;
  endfunction

  // Guards against ids that name a thread slot that does not exist.
  function automatic logic tid_in_range(input int unsigned tid, input int unsigned num_threads);
    return tid < num_threads;
  endfunction

  typedef logic [tid_width(DEFAULT_NUM_THREADS)-1:0] tid_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority picker: first set mask bit after ptr, with wrap
module rr_pick
  import barrel_pkg::*;
#(
  parameter int N  = DEFAULT_NUM_THREADS,
  parameter int TW = tid_width(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [TW-1:0] ptr,
  output logic          found,
  output logic [TW-1:0] idx
);

  logic [TW-1:0] probe;

  // Walk from the farthest slot back toward ptr+1 so the nearest ready slot is the last one kept.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    probe = '0;
    for (int i = N; i >= 1; i--) begin
      probe = ptr + TW'(i);
      if (mask[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/barrel_thread_sched.sv
// rtl/barrel_thread_sched.sv - barrel thread scheduler and PC file; BARREL_PERF_CNT_EN adds perf counters
module barrel_thread_sched
  import barrel_pkg::*;
#(
  parameter int                     NUM_THREADS   = DEFAULT_NUM_THREADS,
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
  parameter int                     PC_STEP       = DEFAULT_PC_STEP,
  parameter bit                     STRICT_BARREL = 1'b1,
  localparam int                    TW            = tid_width(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_THREADS-1:0]   en_mask,
  input  logic                     block_set_valid,
  input  logic [TW-1:0]            block_set_tid,
  input  logic                     block_clr_valid,
  input  logic [TW-1:0]            block_clr_tid,
  input  logic                     redir_valid,
  input  logic [TW-1:0]            redir_tid,
  input  logic [ADDRESS_WIDTH-1:0] redir_pc,
  input  logic                     halt_valid,
  input  logic [TW-1:0]            halt_tid,
  output logic                     issue_valid,
  output logic [TW-1:0]            issue_tid,
  output logic [ADDRESS_WIDTH-1:0] issue_pc,
`ifdef BARREL_PERF_CNT_EN
  input  logic [TW-1:0]            perf_sel,
  output logic [31:0]              perf_cnt,
`endif
  output logic                     all_halted
);

  logic [ADDRESS_WIDTH-1:0] pc [NUM_THREADS];
  logic [NUM_THREADS-1:0]   halted, blocked, ready, halted_next, blocked_next;
  logic [TW-1:0]            ptr, ptr_next, cand, rr_idx;
  logic                     go, rr_found, redir_ok;

  assign ready    = en_mask & ~halted & ~blocked;
  assign redir_ok = redir_valid && tid_in_range(32'(redir_tid), NUM_THREADS);

  rr_pick #(.N(NUM_THREADS), .TW(TW)) u_pick (
    .mask  (ready),
    .ptr   (ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Strict mode walks every slot and bubbles; skip mode jumps to the next ready thread and holds ptr when idle.
  always_comb begin
    cand     = ptr + TW'(1);
    go       = ready[cand];
    ptr_next = cand;
    if (!STRICT_BARREL) begin
      cand     = rr_found ? rr_idx : ptr;
      go       = rr_found;
      ptr_next = cand;
    end
  end

  // Block/halt mask updates; clear is applied last so it beats a same-edge set.
  always_comb begin
    blocked_next = blocked;
    halted_next  = halted;
    if (block_set_valid && tid_in_range(32'(block_set_tid), NUM_THREADS))
      blocked_next[block_set_tid] = 1'b1;
    if (block_clr_valid && tid_in_range(32'(block_clr_tid), NUM_THREADS))
      blocked_next[block_clr_tid] = 1'b0;
    if (halt_valid && tid_in_range(32'(halt_tid), NUM_THREADS))
      halted_next[halt_tid] = 1'b1;
  end

  // PC file: a redirect overrides the post-issue increment of the same thread.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (rst)
        pc[t] <= RESET_PC;
      else if (redir_ok && redir_tid == TW'(t))
        pc[t] <= redir_pc;
      else if (go && cand == TW'(t))
        pc[t] <= pc[t] + ADDRESS_WIDTH'(PC_STEP);
    end
  end

  // Scheduler state and registered issue slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted      <= '0;
      blocked     <= '0;
      ptr         <= TW'(NUM_THREADS - 1);
      issue_valid <= 1'b0;
      issue_tid   <= '0;
      issue_pc    <= '0;
      all_halted  <= 1'b0;
    end else begin
      halted      <= halted_next;
      blocked     <= blocked_next;
      ptr         <= ptr_next;
      issue_valid <= go;
      issue_tid   <= cand;
      issue_pc    <= pc[cand];
      all_halted  <= &(halted_next | ~en_mask);
    end
  end

`ifdef BARREL_PERF_CNT_EN
  logic [31:0] issue_cnt [NUM_THREADS];
  logic [31:0] idle_cnt;

  // Saturating per-thread issue counts, idle-slot count and registered readout of the selected thread.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) issue_cnt[t] <= '0;
      idle_cnt <= '0;
      perf_cnt <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++)
        if (go && cand == TW'(t) && issue_cnt[t] != '1)
          issue_cnt[t] <= issue_cnt[t] + 32'd1;
      if (!go && idle_cnt != '1)
        idle_cnt <= idle_cnt + 32'd1;
      perf_cnt <= issue_cnt[perf_sel];
    end
  end
`endif

endmodule

// File: tb/tb_barrel_thread_sched.sv
// tb/tb_barrel_thread_sched.sv - directed bench running strict and skip schedulers side by side against a model
module tb_barrel_thread_sched;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en_mask;
  logic        block_set_valid, block_clr_valid, redir_valid, halt_valid;
  logic [2:0]  block_set_tid, block_clr_tid, redir_tid, halt_tid;
  logic [31:0] redir_pc;

  logic        o_valid [2];
  logic [2:0]  o_tid   [2];
  logic [31:0] o_pc    [2];
  logic        o_ah    [2];

  always #5 clk = ~clk;

  barrel_thread_sched #(.NUM_THREADS(N), .STRICT_BARREL(1'b1)) u_strict (
    .clk(clk), .rst(rst), .en_mask(en_mask),
    .block_set_valid(block_set_valid), .block_set_tid(block_set_tid),
    .block_clr_valid(block_clr_valid), .block_clr_tid(block_clr_tid),
    .redir_valid(redir_valid), .redir_tid(redir_tid), .redir_pc(redir_pc),
    .halt_valid(halt_valid), .halt_tid(halt_tid),
    .issue_valid(o_valid[0]), .issue_tid(o_tid[0]), .issue_pc(o_pc[0]),
    .all_halted(o_ah[0])
  );

  barrel_thread_sched #(.NUM_THREADS(N), .STRICT_BARREL(1'b0)) u_skip (
    .clk(clk), .rst(rst), .en_mask(en_mask),
    .block_set_valid(block_set_valid), .block_set_tid(block_set_tid),
    .block_clr_valid(block_clr_valid), .block_clr_tid(block_clr_tid),
    .redir_valid(redir_valid), .redir_tid(redir_tid), .redir_pc(redir_pc),
    .halt_valid(halt_valid), .halt_tid(halt_tid),
    .issue_valid(o_valid[1]), .issue_tid(o_tid[1]), .issue_pc(o_pc[1]),
    .all_halted(o_ah[1])
  );

  // Model state per instance: index 0 = strict rotation, 1 = skip-ahead.
  logic [31:0] m_pc   [2][N];
  bit          m_halt [2][N];
  bit          m_blk  [2][N];
  int          m_ptr  [2];
  bit          e_valid [2];
  int          e_tid   [2];
  logic [31:0] e_pc    [2];
  bit          e_ah    [2];
  bit          e_tid_chk [2];

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit ready(input int k, input int t);
    return en_mask[t] && !m_halt[k][t] && !m_blk[k][t];
  endfunction

  task automatic model_edge(input int k);
    int c;
    bit go;
    if (rst) begin
      for (int t = 0; t < N; t++) begin
        m_pc[k][t] = 32'd0; m_halt[k][t] = 1'b0; m_blk[k][t] = 1'b0;
      end
      m_ptr[k] = N - 1;
      e_valid[k] = 1'b0; e_tid[k] = 0; e_pc[k] = 32'd0; e_ah[k] = 1'b0; e_tid_chk[k] = 1'b1;
      return;
    end
    go = 1'b0;
    c  = (m_ptr[k] + 1) % N;
    if (k == 0) begin
      go = ready(k, c);
      m_ptr[k] = c;
    end else begin
      for (int i = 1; i <= N; i++)
        if (!go && ready(k, (m_ptr[k] + i) % N)) begin
          go = 1'b1;
          c  = (m_ptr[k] + i) % N;
        end
      if (go) m_ptr[k] = c;
    end
    e_valid[k]   = go;
    e_tid_chk[k] = go || (k == 0);
    if (go || k == 0) e_tid[k] = c;
    if (go) begin
      e_pc[k]    = m_pc[k][c];
      m_pc[k][c] = m_pc[k][c] + 32'd4;
    end
    if (redir_valid)     m_pc[k][redir_tid] = redir_pc;
    if (block_set_valid) m_blk[k][block_set_tid] = 1'b1;
    if (block_clr_valid) m_blk[k][block_clr_tid] = 1'b0;
    if (halt_valid)      m_halt[k][halt_tid] = 1'b1;
    e_ah[k] = 1'b1;
    for (int t = 0; t < N; t++)
      if (en_mask[t] && !m_halt[k][t]) e_ah[k] = 1'b0;
  endtask

  // Every cycle, both schedulers against the model.
  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("issue_valid[%0d]", k), 32'(o_valid[k]), 32'(e_valid[k]));
        if (e_tid_chk[k]) check($sformatf("issue_tid[%0d]", k), 32'(o_tid[k]), e_tid[k]);
        if (e_valid[k])   check($sformatf("issue_pc[%0d]", k), o_pc[k], e_pc[k]);
        check($sformatf("all_halted[%0d]", k), 32'(o_ah[k]), 32'(e_ah[k]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    block_set_valid = 1'b0; block_clr_valid = 1'b0; redir_valid = 1'b0; halt_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en_mask = 8'hFF;
    block_set_valid = 1'b0; block_clr_valid = 1'b0; redir_valid = 1'b0; halt_valid = 1'b0;
    block_set_tid = '0; block_clr_tid = '0; redir_tid = '0; halt_tid = '0; redir_pc = '0;
    run = 1'b1;
    cyc(); cyc();
    check("rst_valid", 32'(o_valid[0]), 32'd0);
    check("rst_tid",   32'(o_tid[0]),   32'd0);
    check("rst_pc",    o_pc[0],         32'd0);
    rst = 1'b0;

    // Full rotation: 0..7 then 0 again with its PC stepped once.
    for (int i = 0; i < 9; i++) begin
      cyc();
      check($sformatf("rot_tid_%0d", i), 32'(o_tid[0]), i % 8);
      if (i == 0) check("rot_pc_first", o_pc[0], 32'h0);
      if (i == 8) check("rot_pc_second", o_pc[0], 32'h4);
    end

    // Block tid 3: strict bubbles its slot, skip jumps to 4; after clear tid 3 resumes at PC 4.
    block_set_valid = 1'b1; block_set_tid = 3'd3;
    cyc(); cyc(); cyc();
    check("blk_bubble_valid", 32'(o_valid[0]), 32'd0);
    check("blk_bubble_tid",   32'(o_tid[0]),   32'd3);
    check("blk_skip_tid",     32'(o_tid[1]),   32'd4);
    block_clr_valid = 1'b1; block_clr_tid = 3'd3;
    cyc();
    repeat (7) cyc();
    check("blk_resume_tid", 32'(o_tid[0]), 32'd3);
    check("blk_resume_pc",  o_pc[0],       32'h4);

    // Redirect tid 1 on the edge it issues: old PC goes out, new PC on its next slot.
    repeat (5) cyc();
    redir_valid = 1'b1; redir_tid = 3'd1; redir_pc = 32'h100;
    cyc();
    check("redir_same_tid", 32'(o_tid[0]), 32'd1);
    check("redir_same_pc",  o_pc[0],       32'hC);
    repeat (7) cyc();
    block_set_valid = 1'b1; block_set_tid = 3'd2;
    cyc();
    check("redir_next_pc", o_pc[0], 32'h100);

    // tid 2 blocked; set and clear on the same edge leaves it unblocked.
    block_set_valid = 1'b1; block_set_tid = 3'd2;
    block_clr_valid = 1'b1; block_clr_tid = 3'd2;
    cyc();
    check("setclr_bubble", 32'(o_valid[0]), 32'd0);
    repeat (8) cyc();
    check("setclr_valid", 32'(o_valid[0]), 32'd1);
    check("setclr_tid",   32'(o_tid[0]),   32'd2);

    // Mid-run reset with sparse enables: skip mode issues 0,2,5 with no bubbles.
    en_mask = 8'b0010_0101; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      check($sformatf("sparse_valid_%0d", j), 32'(o_valid[1]), 32'd1);
      check($sformatf("sparse_tid_%0d", j), 32'(o_tid[1]), (j % 3 == 0) ? 0 : (j % 3 == 1) ? 2 : 5);
      if (j == 0) check("sparse_strict_pc", o_pc[0], 32'h0);
      if (j == 3) check("sparse_skip_pc",   o_pc[1], 32'h4);
    end

    // Block every enabled thread: skip mode idles with ptr held at 5.
    block_set_valid = 1'b1; block_set_tid = 3'd0; cyc();
    block_set_valid = 1'b1; block_set_tid = 3'd2; cyc();
    block_set_valid = 1'b1; block_set_tid = 3'd5; cyc();
    cyc();
    check("allblk_valid", 32'(o_valid[1]), 32'd0);
    en_mask = 8'b0110_0111;
    cyc();
    check("held_ptr_tid", 32'(o_tid[1]), 32'd6);
    en_mask = 8'b0010_0101;
    block_clr_valid = 1'b1; block_clr_tid = 3'd2; cyc();
    cyc();

    // Halt all enabled threads; redirect a halted thread, which still never issues.
    halt_valid = 1'b1; halt_tid = 3'd0; cyc();
    halt_valid = 1'b1; halt_tid = 3'd2; cyc();
    check("halt_partial", 32'(o_ah[1]), 32'd0);
    halt_valid = 1'b1; halt_tid = 3'd5; cyc();
    check("halt_all", 32'(o_ah[1]), 32'd1);
    redir_valid = 1'b1; redir_tid = 3'd0; redir_pc = 32'h40; cyc();
    cyc();
    check("halt_idle_strict", 32'(o_valid[0]), 32'd0);
    check("halt_idle_skip",   32'(o_valid[1]), 32'd0);

    // Reset again: tid 0 first at PC 0, then PC wrap at the top of the address space.
    en_mask = 8'hFF; rst = 1'b1;
    cyc();
    check("rst2_ah", 32'(o_ah[0]), 32'd0);
    rst = 1'b0;
    redir_valid = 1'b1; redir_tid = 3'd1; redir_pc = 32'hFFFF_FFFC;
    cyc();
    check("rst2_tid", 32'(o_tid[1]), 32'd0);
    check("rst2_pc",  o_pc[1],       32'h0);
    cyc();
    check("wrap_pc_top", o_pc[0], 32'hFFFF_FFFC);
    repeat (8) cyc();
    check("wrap_tid", 32'(o_tid[0]), 32'd1);
    check("wrap_pc",  o_pc[0],       32'h0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/barrel_thread_sched.md
Name: barrel_thread_sched

Overview:
Parametrised thread scheduler and per-thread PC file for the next-generation barrel core. Each cycle it picks one thread to issue and presents that thread's tid and PC to fetch. It tracks per-thread blocked and halted state and accepts branch redirects from writeback. It generalises the fixed 8-thread rotation to any thread count and adds a skip-ahead mode that skips unready threads instead of issuing bubbles.

Parameters:
NUM_THREADS, 8, number of hardware threads (power of two, 2..32)
ADDRESS_WIDTH, 32, PC width
RESET_PC, 0, PC loaded into every thread on reset
PC_STEP, 4, PC increment per issue
STRICT_BARREL, 1, 1 = fixed rotation with bubbles for unready threads; 0 = round-robin skip to next ready thread

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
en_mask  in  NUM_THREADS  thread enable; a bit at 0 never issues
block_set_valid  in  1  block thread block_set_tid (e.g. load miss)
block_set_tid  in  TW  TW = $clog2(NUM_THREADS)
block_clr_valid  in  1  unblock thread block_clr_tid
block_clr_tid  in  TW  thread to unblock
redir_valid  in  1  overwrite PC of redir_tid
redir_tid  in  TW  thread to redirect
redir_pc  in  ADDRESS_WIDTH  new PC
halt_valid  in  1  permanently halt halt_tid until reset
halt_tid  in  TW  thread to halt
issue_valid  out  1  registered; issue slot holds a thread
issue_tid  out  TW  registered issued thread
issue_pc  out  ADDRESS_WIDTH  registered PC of issued thread
all_halted  out  1  registered; every enabled thread halted (or en_mask==0)

Behaviour:
- State: pc[NUM_THREADS], halted mask, blocked mask, ptr (last slot).
- Reset (rst high at edge): all pc=RESET_PC; halted=0; blocked=0; ptr=NUM_THREADS-1; issue_valid=0; issue_tid=0; issue_pc=0; all_halted=0. Reset asserted mid-run discards all state on that edge.
- ready[t] = en_mask[t] & ~halted[t] & ~blocked[t], evaluated from registered state before this edge's updates.
- STRICT_BARREL=1: cand = ptr+1 mod NUM_THREADS; ptr<=cand every cycle. If ready[cand], issue it; otherwise issue_valid<=0 and issue_tid<=cand.
- STRICT_BARREL=0: cand = first ready thread searching ptr+1, ptr+2, ... with wrap. If one is found, issue it and set ptr<=cand. If none is ready, issue_valid<=0 and ptr is held.
- On issue at edge N: issue_valid=1, issue_tid=cand, issue_pc=pc[cand] (old value); pc[cand]<=pc[cand]+PC_STEP, wrapping mod 2^ADDRESS_WIDTH.
- Events sampled at edge N first affect selection at edge N+1 (one-cycle visibility).
- Redirect: pc[redir_tid]<=redir_pc. This wins over the issue increment when the same thread issues on the same edge.
- Block set/clr: if both target the same tid on the same edge, clear wins. Blocking an already-blocked thread is a no-op.
- Halt: sticky until rst. A redirect to a halted thread still updates its pc but the thread never issues.
- all_halted <= &(halted_next | ~en_mask).
- Out-of-range tid (>=NUM_THREADS, non-power-of-two misuse) is ignored.

Optional Feature:
BARREL_PERF_CNT_EN:
- Defined: adds a 32-bit saturating issue counter per thread and a 32-bit idle counter (cycles with issue_valid=0), all cleared on rst.
- Defined: adds ports perf_sel (in, TW) and perf_cnt (out, 32). perf_cnt is a registered readout of the selected thread's counter.
- Undefined: no counters and no perf ports.

Decomposition:
- Package barrel_pkg: TW constant function, DEFAULT_NUM_THREADS, DEFAULT_PC_STEP, tid_t typedef.
- Sub-module rr_pick: a combinational rotating priority picker (mask, ptr -> found, idx), used for STRICT_BARREL=0.

Test Plan:
- Reset then all enabled, STRICT=1, N=8, RESET_PC=0 -> issue_tid 0,1,...,7,0; thread 0 issue_pc 0 then 4 on its second slot.
- STRICT=1, block tid 3 at cycle 2 -> slot for tid 3 shows issue_valid=0 and issue_tid=3; after clr, tid 3 resumes at its old PC.
- STRICT=0, en_mask=8'b0010_0101 -> issue order 0,2,5,0,2,5, no bubbles; all blocked -> issue_valid=0, ptr held.
- Redirect tid 1 to 0x100 on the same edge tid 1 issues at PC 0x8 -> issue_pc=0x8; next tid 1 issue_pc=0x100.
- Set and clr of tid 2 on the same edge -> tid 2 unblocked; halt all enabled threads -> all_halted=1 one edge later, issue_valid stays 0.
- rst pulsed mid-run with PCs nonzero -> all pcs back to RESET_PC and first issue is tid 0 (perf counters zero if BARREL_PERF_CNT_EN is defined).
